// File: rtl/mips150_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips150_pkg
// Description : Shared store-path encodings and types for the MIPS150 DMEM
//               store unit (size codes, DMEM address width, entry layout).
// Revision    : 1.0 - initial release
// ============================================================================
package mips150_pkg;

    // MemAlign size encoding; 2'b11 is illegal
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam int DMEM_ADDR_W = 12;

    // Formatted byte lanes ready for DMEM port A
    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] din;
    } store_lanes_t;

    // One buffered store at the default DMEM width
    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        store_lanes_t           lanes;
    } store_entry_t;

endpackage
`default_nettype wire

// File: rtl/mips150_store_align.sv
`default_nettype none
// ============================================================================
// Module      : mips150_store_align
// Description : Combinational big-endian byte-lane formatter for SB/SH/SW.
//               Produces write-enables, replicated write data and a flag for
//               misaligned or illegal requests.
// Revision    : 1.0 - initial release
// ============================================================================
module mips150_store_align
    import mips150_pkg::*;
(
    input  logic [1:0]   size_i,
    input  logic [1:0]   off_i,
    input  logic [31:0]  data_i,
    output store_lanes_t lanes_o,
    output logic         misalign_o
);

    // Replicate the source bytes across all lanes and pick lanes by offset
    always_comb begin
        lanes_o.we  = 4'b0000;
        lanes_o.din = data_i;
        misalign_o  = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                lanes_o.din = {4{data_i[7:0]}};
                lanes_o.we  = 4'b1000 >> off_i;
            end
            SIZE_HALF: begin
                lanes_o.din = {2{data_i[15:0]}};
                lanes_o.we  = off_i[1] ? 4'b0011 : 4'b1100;
                misalign_o  = off_i[0];
            end
            SIZE_WORD: begin
                lanes_o.din = data_i;
                lanes_o.we  = 4'b1111;
                misalign_o  = (off_i != 2'b00);
            end
            default: begin
                misalign_o  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips150_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips150_store_unit
// Description : MIPS150 store buffer. Formats stores, queues them in a small
//               FIFO, drains into DMEM port A when loads leave the port free,
//               owns the DMEM address mux and flags load/store conflicts.
// Revision    : 1.0 - initial release
// ============================================================================
module mips150_store_unit
    import mips150_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = DMEM_ADDR_W
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [31:0]                st_addr,
    input  logic [31:0]                st_data,
    input  logic [1:0]                 st_size,
    output logic                       st_misalign,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_addr,
    output logic                       ld_conflict,
    output logic [3:0]                 dmem_we,
    output logic [ADDR_W-1:0]          dmem_addr,
    output logic [31:0]                dmem_din,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              misalign_q;

    logic [ADDR_W-1:0] addr_q  [DEPTH];
    store_lanes_t      lanes_q [DEPTH];

    store_lanes_t      w_lanes;
    logic              w_misalign;
    logic              w_accept;
    logic              w_enq;
    logic              w_drain;
    logic              w_hit;
    logic [PTR_W-1:0]  w_idx;
    logic [31-ADDR_W-2:0] w_unused_addr_hi;

    // Byte address bits above the DMEM word range are not decoded
    assign w_unused_addr_hi = st_addr[31:ADDR_W+2];

    mips150_store_align u_align (
        .size_i     (st_size),
        .off_i      (st_addr[1:0]),
        .data_i     (st_data),
        .lanes_o    (w_lanes),
        .misalign_o (w_misalign)
    );

    assign empty       = (count_q == '0);
    assign st_ready    = (count_q != CNT_W'(DEPTH));
    assign count       = count_q;
    assign st_misalign = misalign_q;
    assign w_accept    = st_valid && st_ready;
    assign w_enq       = w_accept && !w_misalign;

    // Compare the load word address against every occupied entry
    always_comb begin
        w_hit = 1'b0;
        w_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[w_idx] == ld_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    assign ld_conflict = ld_valid && w_hit;

    // Load owns the port unless it must wait for a matching store to drain
    assign w_drain   = !empty && (!ld_valid || ld_conflict);
    assign dmem_addr = w_drain ? addr_q[head_q] : ld_addr;
    assign dmem_din  = lanes_q[head_q].din;
    assign dmem_we   = w_drain ? lanes_q[head_q].we : 4'b0000;

    // Next-state pointers and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_drain) begin
            head_d = head_q + 1'b1;
        end
        if (w_enq) begin
            tail_d = tail_q + 1'b1;
        end
        case ({w_enq, w_drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= w_accept && w_misalign;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (w_enq) begin
            addr_q[tail_q]  <= st_addr[ADDR_W+1:2];
            lanes_q[tail_q] <= w_lanes;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips150_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips150_store_unit
// Description : Self-checking bench for mips150_store_unit. Directed scenarios
//               followed by random traffic, all compared each cycle against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips150_store_unit;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;

    logic              clk;
    logic              rst_n;
    logic              st_valid;
    logic              st_ready;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic              st_misalign;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_conflict;
    logic [3:0]        dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_din;
    logic              empty;
    logic [2:0]        count;

    mips150_store_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_size     (st_size),
        .st_misalign (st_misalign),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_din    (dmem_din),
        .empty       (empty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        we;
        logic [31:0]       din;
    } ref_entry_t;

    ref_entry_t ref_q[$];
    logic       ref_mis_pend = 1'b0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, check outputs, then advance the model
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic lv, input logic [ADDR_W-1:0] la,
                        input logic rn);
        ref_entry_t e;
        logic       conflict;
        logic       drain;
        logic       acc;
        logic       bad;
        int         off;
        st_valid = v; st_addr = a; st_data = d; st_size = sz;
        ld_valid = lv; ld_addr = la; rst_n = rn;
        #2;
        conflict = 1'b0;
        foreach (ref_q[i]) if (ref_q[i].addr == la) conflict = lv;
        drain = (ref_q.size() != 0) && (!lv || conflict);

        check("count",     32'(count),       32'(ref_q.size()));
        check("empty",     32'(empty),       32'(ref_q.size() == 0));
        check("st_ready",  32'(st_ready),    32'(ref_q.size() < DEPTH));
        check("misalign",  32'(st_misalign), 32'(ref_mis_pend));
        check("conflict",  32'(ld_conflict), 32'(conflict));
        check("dmem_we",   32'(dmem_we),     drain ? 32'(ref_q[0].we) : 32'd0);
        check("dmem_addr", 32'(dmem_addr),   drain ? 32'(ref_q[0].addr) : 32'(la));
        if (drain) check("dmem_din", dmem_din, ref_q[0].din);

        if (!rn) begin
            ref_q.delete();
            ref_mis_pend = 1'b0;
        end else begin
            acc = v && (ref_q.size() < DEPTH);
            off = int'(a[1:0]);
            bad = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
            if (drain) void'(ref_q.pop_front());
            ref_mis_pend = acc && bad;
            if (acc && !bad) begin
                e.addr = ADDR_W'(a >> 2);
                case (sz)
                    2'd0: begin e.din = 32'(d & 32'hFF) * 32'h0101_0101;   e.we = 4'(1 << (3 - off)); end
                    2'd1: begin e.din = 32'(d & 32'hFFFF) * 32'h0001_0001; e.we = (off >= 2) ? 4'd3 : 4'd12; end
                    default: begin e.din = d; e.we = 4'd15; end
                endcase
                ref_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, 2'd0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0;
        ld_valid = 1'b0; ld_addr = '0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then SB to 0x102
        step(1'b1, 32'h0000_0102, 32'h0000_00AB, 2'd0, 1'b0, '0, 1'b1);
        idle(2);

        // SH then SW back-to-back
        step(1'b1, 32'h6, 32'h0000_1234, 2'd1, 1'b0, '0, 1'b1);
        step(1'b1, 32'h8, 32'hDEAD_BEEF, 2'd2, 1'b0, '0, 1'b1);
        idle(3);

        // Fill while loads hold the port, then let it drain
        for (int k = 0; k < 5; k++)
            step(1'b1, 32'h400 + 32'(k * 4), 32'hA000_0000 + 32'(k), 2'd2, 1'b1, 12'h3FF, 1'b1);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 12'h3FF, 1'b1);
        idle(5);

        // Load conflicting with a buffered store
        step(1'b1, 32'h40, 32'h1111_2222, 2'd2, 1'b0, '0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 12'h010, 1'b1);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 12'h010, 1'b1);

        // Misaligned half and word
        step(1'b1, 32'h3, 32'h5555, 2'd1, 1'b0, '0, 1'b1);
        step(1'b1, 32'h2, 32'h6666, 2'd2, 1'b0, '0, 1'b1);
        idle(2);

        // Reset with stores pending
        for (int k = 0; k < 3; k++)
            step(1'b1, 32'h20 + 32'(k * 4), 32'(k), 2'd2, 1'b1, 12'h3FF, 1'b1);
        step(1'b0, 32'd0, 32'd0, 2'd0, 1'b1, 12'h3FF, 1'b0);
        idle(3);

        // Random traffic over a narrow address window to provoke conflicts
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) != 0),
                 32'($urandom_range(0, 31)) | (32'($urandom) & 32'hFFFF_C000),
                 $urandom,
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1),
                 ADDR_W'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
